// File: rtl/uart_rx_cmd_decoder.sv
// Frame-level command decoder behind the UART receiver: assembles write, read and ALU command
// frames from received bytes and issues registered register-file / ALU strobes.
module uart_rx_cmd_decoder #(
    parameter int unsigned DSIZE      = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned TMO_CYCLES = 255,
    parameter int unsigned TMO_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DSIZE-1:0]  RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic              PAR_ERR,
    input  logic              STP_ERR,
    output logic              WR_EN,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DSIZE-1:0]  WR_DATA,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    output logic              CLK_GATE_EN,
    output logic              FRAME_ERR,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StAluA,
        StAluB,
        StAluFun
    } state_t;

    localparam logic [DSIZE-1:0] CmdWr     = DSIZE'(8'hAA);
    localparam logic [DSIZE-1:0] CmdRd     = DSIZE'(8'hBB);
    localparam logic [DSIZE-1:0] CmdAluOp  = DSIZE'(8'hCC);
    localparam logic [DSIZE-1:0] CmdAluFun = DSIZE'(8'hDD);
    // Count value at which one more idle cycle would reach TMO_CYCLES.
    localparam logic [TMO_W-1:0] TmoLast   = TMO_W'(TMO_CYCLES - 1);

    state_t           state_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             byte_err;
    logic             tmo_expire;

    assign byte_err   = PAR_ERR | STP_ERR;
    assign tmo_expire = (TMO_CYCLES != 0) && (tmo_cnt_q == TmoLast);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            WR_EN       <= 1'b0;
            RD_EN       <= 1'b0;
            ADDR        <= '0;
            WR_DATA     <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            FRAME_ERR   <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            WR_EN       <= 1'b0;
            RD_EN       <= 1'b0;
            ALU_EN      <= 1'b0;
            FRAME_ERR   <= 1'b0;
            CLK_GATE_EN <= 1'b0;

            if (RX_D_VLD) begin
                tmo_cnt_q <= '0;
                if (byte_err) begin
                    FRAME_ERR <= 1'b1;
                    state_q   <= StIdle;
                    BUSY      <= 1'b0;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (RX_P_DATA == CmdWr) begin
                                state_q <= StWrAddr;
                                BUSY    <= 1'b1;
                            end else if (RX_P_DATA == CmdRd) begin
                                state_q <= StRdAddr;
                                BUSY    <= 1'b1;
                            end else if (RX_P_DATA == CmdAluOp) begin
                                state_q <= StAluA;
                                BUSY    <= 1'b1;
                            end else if (RX_P_DATA == CmdAluFun) begin
                                state_q     <= StAluFun;
                                BUSY        <= 1'b1;
                                CLK_GATE_EN <= 1'b1;
                            end else begin
                                FRAME_ERR <= 1'b1;
                            end
                        end
                        StWrAddr: begin
                            ADDR    <= RX_P_DATA[ADDR_W-1:0];
                            state_q <= StWrData;
                        end
                        StWrData: begin
                            WR_DATA <= RX_P_DATA;
                            WR_EN   <= 1'b1;
                            state_q <= StIdle;
                            BUSY    <= 1'b0;
                        end
                        StRdAddr: begin
                            ADDR    <= RX_P_DATA[ADDR_W-1:0];
                            RD_EN   <= 1'b1;
                            state_q <= StIdle;
                            BUSY    <= 1'b0;
                        end
                        // Operands land in fixed register-file slots 0 and 1.
                        StAluA: begin
                            ADDR    <= '0;
                            WR_DATA <= RX_P_DATA;
                            WR_EN   <= 1'b1;
                            state_q <= StAluB;
                        end
                        StAluB: begin
                            ADDR        <= ADDR_W'(1);
                            WR_DATA     <= RX_P_DATA;
                            WR_EN       <= 1'b1;
                            state_q     <= StAluFun;
                            CLK_GATE_EN <= 1'b1;
                        end
                        StAluFun: begin
                            ALU_FUN     <= RX_P_DATA[3:0];
                            ALU_EN      <= 1'b1;
                            CLK_GATE_EN <= 1'b1;
                            state_q     <= StIdle;
                            BUSY        <= 1'b0;
                        end
                        default: begin
                            state_q <= StIdle;
                            BUSY    <= 1'b0;
                        end
                    endcase
                end
            end else if (state_q != StIdle) begin
                if (tmo_expire) begin
                    FRAME_ERR <= 1'b1;
                    tmo_cnt_q <= '0;
                    state_q   <= StIdle;
                    BUSY      <= 1'b0;
                end else begin
                    if (TMO_CYCLES != 0) begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                    CLK_GATE_EN <= (state_q == StAluFun);
                end
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Directed bench for uart_rx_cmd_decoder: expected strobes are queued with their due cycle and
// matched by a negedge monitor; state-level outputs are checked inline.
module tb_uart_rx_cmd_decoder;

    localparam int unsigned DSIZE  = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned TMO    = 10;

    logic              CLK = 1'b0;
    logic              RST;
    logic [DSIZE-1:0]  RX_P_DATA;
    logic              RX_D_VLD;
    logic              PAR_ERR;
    logic              STP_ERR;
    logic              WR_EN;
    logic              RD_EN;
    logic [ADDR_W-1:0] ADDR;
    logic [DSIZE-1:0]  WR_DATA;
    logic              ALU_EN;
    logic [3:0]        ALU_FUN;
    logic              CLK_GATE_EN;
    logic              FRAME_ERR;
    logic              BUSY;

    uart_rx_cmd_decoder #(
        .DSIZE      (DSIZE),
        .ADDR_W     (ADDR_W),
        .TMO_CYCLES (TMO),
        .TMO_W      (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .PAR_ERR     (PAR_ERR),
        .STP_ERR     (STP_ERR),
        .WR_EN       (WR_EN),
        .RD_EN       (RD_EN),
        .ADDR        (ADDR),
        .WR_DATA     (WR_DATA),
        .ALU_EN      (ALU_EN),
        .ALU_FUN     (ALU_FUN),
        .CLK_GATE_EN (CLK_GATE_EN),
        .FRAME_ERR   (FRAME_ERR),
        .BUSY        (BUSY)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic              wr;
        logic              rd;
        logic              alu;
        logic              fe;
        logic [ADDR_W-1:0] addr;
        logic [DSIZE-1:0]  data;
        logic [3:0]        fun;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        ev_t         ev;
    } exp_t;

    exp_t              q[$];
    logic [ADDR_W-1:0] m_addr;
    logic [DSIZE-1:0]  m_data;
    logic [3:0]        m_fun;
    int                checks = 0;
    int                errors = 0;

    task automatic push(input int unsigned dly, input logic wr, input logic rd,
                        input logic alu, input logic fe);
        exp_t e;
        e.cyc = cyc + dly;
        e.ev  = '{wr, rd, alu, fe, m_addr, m_data, m_fun};
        q.push_back(e);
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [DSIZE-1:0] d);
        m_addr = a;
        m_data = d;
        push(1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic exp_rd(input logic [ADDR_W-1:0] a);
        m_addr = a;
        push(1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic exp_alu(input logic [3:0] f);
        m_fun = f;
        push(1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic exp_fe(input int unsigned dly);
        push(dly, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte starting at a negedge; returns at the negedge where its result is visible.
    task automatic send(input logic [7:0] b, input logic p = 1'b0, input logic s = 1'b0);
        RX_P_DATA = b;
        PAR_ERR   = p;
        STP_ERR   = s;
        RX_D_VLD  = 1'b1;
        @(negedge CLK);
        RX_D_VLD  = 1'b0;
        PAR_ERR   = 1'b0;
        STP_ERR   = 1'b0;
    endtask

    always @(negedge CLK) begin : monitor
        ev_t  obs;
        exp_t e;
        obs = '{WR_EN, RD_EN, ALU_EN, FRAME_ERR, ADDR, WR_DATA, ALU_FUN};
        if (obs.wr || obs.rd || obs.alu || obs.fe || (q.size() > 0 && q[0].cyc == cyc)) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
            end else begin
                e.cyc = cyc;
                e.ev  = '{1'b0, 1'b0, 1'b0, 1'b0, m_addr, m_data, m_fun};
            end
            checks++;
            assert (obs === e.ev) else begin
                errors++;
                $error("FAIL strobe@%0d: observed %h expected %h", cyc, obs, e.ev);
            end
        end
    end

    initial begin
        RST       = 1'b0;
        RX_D_VLD  = 1'b0;
        RX_P_DATA = '0;
        PAR_ERR   = 1'b0;
        STP_ERR   = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        m_fun     = '0;
        repeat (2) @(negedge CLK);
        check("rst_strobes", {WR_EN, RD_EN, ALU_EN, FRAME_ERR, CLK_GATE_EN, BUSY}, 0);
        check("rst_fields", {ADDR, WR_DATA, ALU_FUN}, 0);
        RST = 1'b1;
        @(negedge CLK);

        // Write frame
        send(8'hAA);
        check("wr_busy_cmd", BUSY, 1);
        send(8'h05);
        check("wr_busy_addr", BUSY, 1);
        exp_wr(4'h5, 8'h3C);
        send(8'h3C);
        check("wr_idle", BUSY, 0);

        // Read frame with upper address bits ignored
        send(8'hBB);
        exp_rd(4'h7);
        send(8'hF7);
        check("rd_idle", BUSY, 0);

        // ALU frame with operands
        send(8'hCC);
        check("alu_cge_a", CLK_GATE_EN, 0);
        exp_wr(4'h0, 8'h12);
        send(8'h12);
        check("alu_cge_b", CLK_GATE_EN, 0);
        exp_wr(4'h1, 8'h34);
        send(8'h34);
        check("alu_cge_fun", CLK_GATE_EN, 1);
        @(negedge CLK);
        check("alu_cge_wait", CLK_GATE_EN, 1);
        exp_alu(4'hA);
        send(8'h0A);
        check("alu_cge_en", CLK_GATE_EN, 1);
        @(negedge CLK);
        check("alu_cge_off", CLK_GATE_EN, 0);

        // Unknown command and byte errors
        exp_fe(1);
        send(8'h55);
        check("unk_idle", BUSY, 0);
        send(8'hAA);
        exp_fe(1);
        send(8'h05, 1'b1, 1'b0);
        check("par_idle", BUSY, 0);
        send(8'hAA);
        exp_fe(1);
        send(8'h05, 1'b0, 1'b1);
        check("stp_idle", BUSY, 0);

        // Inter-byte timeout
        send(8'hAA);
        exp_fe(TMO);
        repeat (TMO - 1) @(negedge CLK);
        check("tmo_busy_before", BUSY, 1);
        @(negedge CLK);
        check("tmo_busy_after", BUSY, 0);
        send(8'hAA);
        send(8'h09);
        exp_wr(4'h9, 8'h5A);
        send(8'h5A);

        // Byte arriving on the expiry cycle wins
        send(8'hAA);
        repeat (TMO - 1) @(negedge CLK);
        send(8'h06);
        check("tmo_race_busy", BUSY, 1);
        exp_wr(4'h6, 8'h77);
        send(8'h77);

        // Back-to-back FUN frame
        send(8'hDD);
        exp_alu(4'h3);
        send(8'h03);

        // Reset mid-frame
        send(8'hCC);
        exp_wr(4'h0, 8'h12);
        send(8'h12);
        #1;
        RST    = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_fun  = '0;
        #1;
        check("midrst_strobes", {WR_EN, RD_EN, ALU_EN, FRAME_ERR, CLK_GATE_EN, BUSY}, 0);
        check("midrst_fields", {ADDR, WR_DATA, ALU_FUN}, 0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send(8'hBB);
        exp_rd(4'h2);
        send(8'h02);

        repeat (3) @(negedge CLK);
        check("sb_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
